// File: rtl/rr_lzc_arbiter.sv
// Round-robin valid/ready arbiter built on trailing-zero counters.
// A stalled selection can be locked until the downstream accepts it.

module lzc #(
  parameter int WIDTH = 4,
  parameter bit MODE  = 1'b0,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_in,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_empty
);

  logic [CNT_W-1:0] w_cnt;

  // MODE 0: index of lowest set bit; MODE 1: leading-zero count.
  always_comb begin
    w_cnt = '0;
    if (!MODE) begin
      for (int k = WIDTH - 1; k >= 0; k--) begin
        if (i_in[k]) w_cnt = CNT_W'(k);
      end
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (i_in[k]) w_cnt = CNT_W'(WIDTH - 1 - k);
      end
    end
  end

  assign o_cnt   = w_cnt;
  assign o_empty = ~|i_in;

endmodule

module rr_lzc_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter bit LOCK_IN    = 1'b1,
  parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          req_o,
  input  logic                          gnt_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [IDX_W-1:0]              idx_o
);

  logic [IDX_W-1:0]      r_rr;
  logic                  r_lock;
  logic [IDX_W-1:0]      r_lock_idx;

  logic [NUM_REQ-1:0]    w_mask;
  logic [NUM_REQ-1:0]    w_req_m;
  logic [IDX_W-1:0]      w_idx_m;
  logic [IDX_W-1:0]      w_idx_a;
  logic                  w_empty_m;
  logic                  w_empty_a;
  logic [IDX_W-1:0]      w_arb;
  logic [IDX_W-1:0]      w_sel;
  logic                  w_req;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];

  // Requesters above the last winner take precedence; empty mask wraps.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_mask[k] = (k > int'(r_rr));
    end
  end

  assign w_req_m = req_i & w_mask;

  lzc #(
    .WIDTH (NUM_REQ),
    .MODE  (1'b0),
    .CNT_W (IDX_W)
  ) u_lzc_m (
    .i_in    (w_req_m),
    .o_cnt   (w_idx_m),
    .o_empty (w_empty_m)
  );

  lzc #(
    .WIDTH (NUM_REQ),
    .MODE  (1'b0),
    .CNT_W (IDX_W)
  ) u_lzc_a (
    .i_in    (req_i),
    .o_cnt   (w_idx_a),
    .o_empty (w_empty_a)
  );

  always_comb begin
    w_arb = '0;
    if (!w_empty_m)      w_arb = w_idx_m;
    else if (!w_empty_a) w_arb = w_idx_a;
  end

  assign w_sel = r_lock ? r_lock_idx : w_arb;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_data[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_req  = req_i[w_sel];
  assign w_xfer = w_req & gnt_i;

  assign req_o  = w_req;
  assign idx_o  = w_sel;
  assign data_o = w_data[w_sel];
  assign gnt_o  = w_xfer ? (NUM_REQ'(1) << w_sel) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_rr       <= IDX_W'(NUM_REQ - 1);
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_xfer) begin
      r_rr   <= w_sel;
      r_lock <= 1'b0;
    end else if (LOCK_IN && w_req && !r_lock) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel;
    end else if (r_lock && !req_i[r_lock_idx]) begin
      // Held requester withdrew: drop the lock, keep the pointer.
      r_lock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_lzc_arbiter.sv
// Directed bench for rr_lzc_arbiter: locking and non-locking
// instances share one stimulus stream.

module tb_rr_lzc_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [N-1:0]  req;
  logic [N*DW-1:0] data;
  logic          gnt_in;

  logic [N-1:0]  l_gnt, n_gnt;
  logic          l_req, n_req;
  logic [DW-1:0] l_data, n_data;
  logic [IW-1:0] l_idx, n_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_lzc_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .LOCK_IN(1'b1)
  ) u_lock (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_i(req), .data_i(data), .gnt_o(l_gnt),
    .req_o(l_req), .gnt_i(gnt_in), .data_o(l_data),
    .idx_o(l_idx)
  );

  rr_lzc_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .LOCK_IN(1'b0)
  ) u_nolock (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_i(req), .data_i(data), .gnt_o(n_gnt),
    .req_o(n_req), .gnt_i(gnt_in), .data_o(n_data),
    .idx_o(n_idx)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled at the falling edge.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    flush  = 1'b0;
    req    = '0;
    gnt_in = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] oh;
    for (int k = 0; k < N; k++) data[k*DW +: DW] = 32'hD000_0000 + k;

    // Reset state
    do_reset();
    rst_n = 1'b0;
    sample();
    chk("rst_gnt", 32'(l_gnt), 32'h0);
    chk("rst_req", 32'(l_req), 32'h0);
    chk("rst_idx", 32'(l_idx), 32'h0);
    step();
    rst_n = 1'b1;

    // All requesting, always accepted: 0,1,2,3,0,1,2,3
    req = 4'b1111; gnt_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      oh = 4'b0001 << (i % 4);
      chk("rr_idx", 32'(l_idx), 32'(i % 4));
      chk("rr_gnt", 32'(l_gnt), 32'(oh));
      chk("rr_dat", l_data, 32'hD000_0000 + 32'(i % 4));
      chk("rr_nl_idx", 32'(n_idx), 32'(i % 4));
      step();
    end

    // Sparse requests 1010: 1,3,1,3
    do_reset();
    req = 4'b1010; gnt_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("sp_idx", 32'(l_idx), (i % 2 == 0) ? 32'd1 : 32'd3);
      chk("sp_gnt", 32'(l_gnt), (i % 2 == 0) ? 32'h2 : 32'h8);
      step();
    end

    // Stall: lock holds 1, no-lock re-arbitrates
    do_reset();
    req = 4'b0110; gnt_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("st_idx", 32'(l_idx), 32'd1);
      chk("st_gnt", 32'(l_gnt), 32'h0);
      chk("st_nl_idx", 32'(n_idx), 32'd1);
      step();
    end
    req = 4'b0111;
    sample();
    chk("lk_hold_idx", 32'(l_idx), 32'd1);
    chk("nl_sw_idx", 32'(n_idx), 32'd0);
    chk("nl_sw_gnt", 32'(n_gnt), 32'h0);
    step();
    gnt_in = 1'b1;
    sample();
    chk("lk_acc_idx", 32'(l_idx), 32'd1);
    chk("lk_acc_gnt", 32'(l_gnt), 32'h2);
    chk("nl_acc_gnt", 32'(n_gnt), 32'h1);
    step();
    sample();
    chk("lk_next_idx", 32'(l_idx), 32'd2);
    chk("lk_next_gnt", 32'(l_gnt), 32'h4);
    chk("nl_next_idx", 32'(n_idx), 32'd1);
    step();

    // Lock on 2, requester 2 withdraws
    do_reset();
    req = 4'b0100; gnt_in = 1'b0;
    sample();
    chk("wd_lock_idx", 32'(l_idx), 32'd2);
    step();
    req = 4'b1010;
    sample();
    chk("wd_idx", 32'(l_idx), 32'd2);
    chk("wd_req", 32'(l_req), 32'h0);
    chk("wd_gnt", 32'(l_gnt), 32'h0);
    step();
    gnt_in = 1'b1;
    sample();
    chk("wd_after_idx", 32'(l_idx), 32'd1);
    chk("wd_after_gnt", 32'(l_gnt), 32'h2);
    step();

    // Lock on 3, flush mid-lock
    do_reset();
    req = 4'b1000; gnt_in = 1'b0;
    step();
    flush = 1'b1; req = 4'b1001;
    sample();
    chk("fl_held_idx", 32'(l_idx), 32'd3);
    chk("fl_held_req", 32'(l_req), 32'h1);
    step();
    flush = 1'b0;
    sample();
    chk("fl_after_idx", 32'(l_idx), 32'd0);
    chk("fl_after_dat", l_data, 32'hD000_0000);
    step();

    // Lock on 3, reset mid-lock
    do_reset();
    req = 4'b1000; gnt_in = 1'b0;
    step();
    rst_n = 1'b0; req = 4'b1001;
    sample();
    chk("rl_held_idx", 32'(l_idx), 32'd3);
    step();
    rst_n = 1'b1;
    sample();
    chk("rl_after_idx", 32'(l_idx), 32'd0);
    step();

    // Flush together with a transfer
    do_reset();
    req = 4'b1111; gnt_in = 1'b1;
    step();
    flush = 1'b1;
    sample();
    chk("ft_idx", 32'(l_idx), 32'd1);
    chk("ft_gnt", 32'(l_gnt), 32'h2);
    step();
    flush = 1'b0;
    sample();
    chk("ft_after_idx", 32'(l_idx), 32'd0);
    step();

    // Downstream ready with no request
    req = 4'b0000; gnt_in = 1'b1;
    sample();
    chk("idle_req", 32'(l_req), 32'h0);
    chk("idle_gnt", 32'(l_gnt), 32'h0);
    chk("idle_idx", 32'(l_idx), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_lzc_arbiter.md
# rr_lzc_arbiter

Round-robin arbiter with a valid/ready handshake that shares a single downstream port between NUM_REQ requesters. Selection uses trailing-zero / leading-zero counting: `lzc` is instantiated in trailing-zero mode on the masked and unmasked request vectors. The block holds a round-robin pointer and a lock register, so a stalled grant is never re-arbitrated. It sits in front of shared resources such as the cache refill port, the PTW memory port and the FPU issue port, and replaces ad-hoc fixed-priority muxes.

## Interface
- NUM_REQ, 4, number of requesters; must be ≥1; IDX_W = max(1, $clog2(NUM_REQ)).
- DATA_WIDTH, 32, payload width per requester.
- LOCK_IN, 1, when 1 a presented-but-not-accepted selection is held until accepted; when 0 it is re-arbitrated every cycle.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  synchronous, active-low reset, sampled on the rising edge of clk_i.
- flush_i  in  1  synchronous clear of the lock and the round-robin pointer; no other state.
- req_i  in  NUM_REQ  per-requester valid.
- data_i  in  NUM_REQ*DATA_WIDTH  payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- gnt_o  out  NUM_REQ  one-hot acceptance back to the requesters.
- req_o  out  1  downstream valid.
- gnt_i  in  1  downstream ready.
- data_o  out  DATA_WIDTH  payload of the selected requester.
- idx_o  out  IDX_W  index of the selected requester.

## Operation
- State:
  - rr_q (IDX_W): index of the last accepted requester.
  - lock_q (1): a selection is being held.
  - lock_idx_q (IDX_W): the held index.
- Arbitration, when not locked:
  - mask[k] = (k > rr_q).
  - If req_i & mask ≠ 0, sel = lowest set index of req_i & mask.
  - Otherwise sel = lowest set index of req_i.
  - Both lowest-index results come from `lzc` in trailing-zero mode; the empty flag chooses between them.
- Locked: sel = lock_idx_q.
- Outputs (all combinational from current state and inputs):
  - req_o = req_i[sel].
  - idx_o = sel.
  - data_o = data_i slice sel.
  - gnt_o = onehot(sel) when req_o & gnt_i, else 0.
  - When req_i = 0 and not locked: idx_o = 0, data_o = slice 0, req_o = 0.
- Handshake: a transfer occurs in any cycle with req_o & gnt_i.
  - Requesters must hold req_i and data_i stable until their gnt_o bit is set.
  - The downstream port may hold gnt_i high without req_o.
- State transitions, highest priority first:
  - rst_ni=0: rr_q ← NUM_REQ-1, lock_q ← 0, lock_idx_q ← 0.
  - flush_i=1: same values as reset.
  - Transfer: rr_q ← sel, lock_q ← 0.
  - LOCK_IN=1 & req_o & !gnt_i & !lock_q: lock_q ← 1, lock_idx_q ← sel.
  - lock_q & !req_i[lock_idx_q] (protocol violation, requester withdrew): lock_q ← 0. Arbitration resumes next cycle and rr_q is unchanged.
- NUM_REQ=1: rr_q and mask are constant; the block degenerates to a wire plus lock.
- NUM_REQ not a power of two: indices ≥ NUM_REQ are never selected. rr_q wrap-around happens because mask is empty when rr_q = NUM_REQ-1.

## Timing
- Zero-cycle latency: req_i to req_o, and gnt_i to gnt_o, are combinational paths.
- Pointer and lock update one cycle after the deciding edge. A new selection is visible in the cycle after a transfer.
- Reset values of outputs while rst_ni=0: with req_i=0, gnt_o=0, req_o=0, idx_o=0. The first post-reset grant favours index 0 because rr_q = NUM_REQ-1.
- Reset or flush asserted mid-lock: lock is dropped at that edge, and arbitration restarts from index 0 in the next cycle.
- Simultaneous flush_i and transfer: the transfer still completes in that cycle (gnt_o asserted). The state takes the flush values.
- Fairness: with all requesters continuously active, each is granted exactly once every NUM_REQ transfers.
- Worst-case wait for an active requester is NUM_REQ-1 transfers.

## Test plan
- Reset then req_i=4'b1111, gnt_i=1 for 8 cycles -> idx_o sequence 0,1,2,3,0,1,2,3; gnt_o one-hot matching each cycle.
- req_i=4'b1010, gnt_i=1 from reset -> idx_o 1,3,1,3; gnt_o 4'b0010, 4'b1000 alternating.
- LOCK_IN=1, req_i=4'b0110, gnt_i=0 for 3 cycles, then req_i=4'b0111 and gnt_i=1 -> idx_o stays 1 throughout; first gnt_o=4'b0010; next idx_o=2.
- LOCK_IN=0, same stimulus as the previous scenario -> idx_o recomputed each cycle (remains 1 since rr_q is unchanged). Then raise req_i[0] while rr_q=3 -> idx_o switches to 0 without a transfer.
- Locked on index 2, then req_i[2] drops with gnt_i=0 -> req_o=0 that cycle; lock_q clears; the next cycle arbitrates normally with rr_q unchanged.
- Locked on index 3, then flush_i=1 one cycle with gnt_i=0 -> lock cleared; with req_i=4'b1001 the next idx_o=0. Repeat the check with rst_ni=0 mid-lock and expect identical results.
